// File: rtl/tl_pkg.sv
// Shared TileLink-UH definitions for the error responder.
//   - A/D channel opcode constants
//   - resp_state_e : responder FSM states
//   - num_beats    : beats carried by a transfer of a given log2 size
//   - a_has_data   : A opcode carries write data
//   - d_has_data   : response to this A opcode carries data beats
//   - d_opcode_of  : A opcode to D response opcode
package tl_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGICAL     = 3'd3;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] HINT        = 3'd5;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] HINT_ACK        = 3'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    A_DRAIN = 2'd1,
    D_SEND  = 2'd2
  } resp_state_e;

  function automatic int unsigned num_beats(input int unsigned size,
                                            input int unsigned lg_beat);
    if (size <= lg_beat) return 1;
    else                 return 1 << (size - lg_beat);
  endfunction

  function automatic logic a_has_data(input logic [2:0] opcode);
    return (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) ||
           (opcode == ARITH)    || (opcode == LOGICAL);
  endfunction

  // Everything except Put and Hint is answered with data beats; the two
  // opcodes illegal on UH (6, 7) are treated like a Get.
  function automatic logic d_has_data(input logic [2:0] opcode);
    return !((opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == HINT));
  endfunction

  function automatic logic [2:0] d_opcode_of(input logic [2:0] opcode);
    if ((opcode == PUT_FULL) || (opcode == PUT_PARTIAL)) return ACCESS_ACK;
    else if (opcode == HINT)                              return HINT_ACK;
    else                                                  return ACCESS_ACK_DATA;
  endfunction

endpackage

// File: rtl/tl_error_responder.sv
// TileLink-UH error/denial responder. Accepts any A-channel request, drains
// the write beats of multi-beat bursts and answers with a denied D response
// of the correct length (data beats are zero and marked corrupt).
//
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   a_valid/a_ready               A beat handshake
//   a_opcode, a_size, a_source    A beat header (only the first beat is used)
//   d_valid/d_ready               D beat handshake
//   d_opcode .. d_corrupt         D beat fields, all derived from header regs
//   busy                          a transaction is in progress
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the first beat of a request
// A_DRAIN | swallowing the remaining write beats of a burst
// D_SEND  | presenting denied D beats until the last one is taken
module tl_error_responder
  import tl_pkg::*;
#(
  parameter int BEAT_BYTES = 8,
  parameter int SOURCE_W   = 8,
  parameter int SIZE_W     = 4,
  parameter int CNT_W      = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [2:0]              a_opcode,
  input  logic [SIZE_W-1:0]       a_size,
  input  logic [SOURCE_W-1:0]     a_source,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [2:0]              d_opcode,
  output logic [1:0]              d_param,
  output logic [SIZE_W-1:0]       d_size,
  output logic [SOURCE_W-1:0]     d_source,
  output logic                    d_sink,
  output logic                    d_denied,
  output logic [8*BEAT_BYTES-1:0] d_data,
  output logic                    d_corrupt,
  output logic                    busy
);

  localparam int unsigned LG_BEAT = $clog2(BEAT_BYTES);

  resp_state_e         state, state_nxt;
  logic [CNT_W-1:0]    a_cnt, a_cnt_nxt;
  logic [CNT_W-1:0]    d_cnt, d_cnt_nxt;
  logic [2:0]          hdr_opcode;
  logic [SIZE_W-1:0]   hdr_size;
  logic [SOURCE_W-1:0] hdr_source;
  logic                hdr_ld;

  int unsigned         a_beats;
  int unsigned         hdr_beats;
  logic [CNT_W-1:0]    new_d_cnt;
  logic [CNT_W-1:0]    hdr_d_cnt;

  assign a_beats   = num_beats(32'(a_size), LG_BEAT);
  assign hdr_beats = num_beats(32'(hdr_size), LG_BEAT);
  assign new_d_cnt = d_has_data(a_opcode)   ? CNT_W'(a_beats - 1)   : '0;
  assign hdr_d_cnt = d_has_data(hdr_opcode) ? CNT_W'(hdr_beats - 1) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      a_cnt      <= '0;
      d_cnt      <= '0;
      hdr_opcode <= '0;
      hdr_size   <= '0;
      hdr_source <= '0;
    end else begin
      state <= state_nxt;
      a_cnt <= a_cnt_nxt;
      d_cnt <= d_cnt_nxt;
      if (hdr_ld) begin
        hdr_opcode <= a_opcode;
        hdr_size   <= a_size;
        hdr_source <= a_source;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    a_cnt_nxt = a_cnt;
    d_cnt_nxt = d_cnt;
    hdr_ld    = 1'b0;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          hdr_ld = 1'b1;
          if (a_has_data(a_opcode) && (a_beats > 1)) begin
            // first beat is being taken now, so the counter holds beats-2
            a_cnt_nxt = CNT_W'(a_beats - 2);
            state_nxt = A_DRAIN;
          end else begin
            d_cnt_nxt = new_d_cnt;
            state_nxt = D_SEND;
          end
        end
      end
      A_DRAIN: begin
        a_ready = 1'b1;
        if (a_valid) begin
          if (a_cnt == '0) begin
            d_cnt_nxt = hdr_d_cnt;
            state_nxt = D_SEND;
          end else begin
            a_cnt_nxt = a_cnt - CNT_W'(1);
          end
        end
      end
      D_SEND: begin
        d_valid = 1'b1;
        if (d_ready) begin
          if (d_cnt == '0) state_nxt = IDLE;
          else             d_cnt_nxt = d_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign d_opcode  = d_opcode_of(hdr_opcode);
  assign d_param   = '0;
  assign d_size    = hdr_size;
  assign d_source  = hdr_source;
  assign d_sink    = 1'b0;
  assign d_denied  = 1'b1;
  assign d_data    = '0;
  assign d_corrupt = d_has_data(hdr_opcode);
  assign busy      = (state != IDLE);

endmodule
